mux_scan_nto1: RTL and testbench

- Parametrised, registered N:1 multiplexer for the lab datapath library. It generalises the 4-input mux/encoder to CH channels of W bits each.
- Four operating modes:
  - DIRECT: externally selected channel.
  - SCAN: round-robin, time-division scan with a programmable dwell.
  - PRIORITY: lowest-index valid channel wins.
  - HOLD: outputs frozen.
- Output is registered, with valid, channel-index and error flags, so it feeds downstream sequential logic directly.

---
 rtl/mux_scan_nto1_if.sv | 18 +
 rtl/mux_scan_nto1.sv | 102 ++++++++++
 tb/tb_mux_scan_nto1.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mux_scan_nto1_if.sv
// mux_scan_nto1_if: channel bus and registered result bus of the N:1 scanning mux
interface mux_scan_nto1_if #(
  parameter int CH = 4,
  parameter int W  = 8
) ();
  localparam int SW = $clog2(CH);
  logic            En;
  logic [1:0]      Mode;
  logic [SW-1:0]   Sel;
  logic [CH*W-1:0] Din;
  logic [CH-1:0]   Din_vld;
  logic [W-1:0]    Do;
  logic            Do_vld;
  logic [SW-1:0]   Do_ch;
  logic            Err;
  modport master (output En, Mode, Sel, Din, Din_vld, input Do, Do_vld, Do_ch, Err);
  modport slave  (input En, Mode, Sel, Din, Din_vld, output Do, Do_vld, Do_ch, Err);
endinterface

// File: rtl/mux_scan_nto1.sv
// mux_scan_nto1: registered CH:1 mux with direct, round-robin scan, priority and hold modes
module mux_scan_nto1 #(
  parameter int CH    = 4,
  parameter int W     = 8,
  parameter int DWELL = 4
) (
  input logic             Clk,
  input logic             Rst_n,
  mux_scan_nto1_if.slave  bus
);
  localparam int SW = $clog2(CH);
  localparam logic [SW-1:0] P_LAST = SW'(CH - 1);
  localparam logic [7:0]    D_LAST = 8'(DWELL - 1);
  typedef enum logic [1:0] {M_DIRECT, M_SCAN, M_PRIO, M_HOLD} mode_t;
  mode_t         r_prev, w_mode;
  logic [W-1:0]  r_do, w_do;
  logic          r_vld, w_vld;
  logic [SW-1:0] r_ch, w_ch;
  logic          r_err, w_err;
  logic [SW-1:0] r_ptr, w_ptr, w_ptr_n;
  logic [7:0]    r_dwell, w_dwell, w_dwell_n;
  logic          w_entry, w_last, w_sel_ok, w_pany;
  logic [SW-1:0] w_pk;
  logic [W-1:0]  w_data [CH];
  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign w_data[g] = bus.Din[g*W +: W];
  end
  assign w_mode   = mode_t'(bus.Mode);
  // entering SCAN restarts at channel 0 with a full dwell, whatever ptr was left at
  assign w_entry  = (w_mode == M_SCAN) && (r_prev != M_SCAN);
  assign w_ptr    = w_entry ? '0 : r_ptr;
  assign w_dwell  = w_entry ? '0 : r_dwell;
  assign w_last   = w_dwell == D_LAST;
  assign w_sel_ok = 32'(bus.Sel) < CH;
  always_comb begin
    w_pk   = '0;
    w_pany = 1'b0;
    for (int k = CH - 1; k >= 0; k--)
      if (bus.Din_vld[k]) begin
        w_pk   = SW'(k);
        w_pany = 1'b1;
      end
  end
  always_comb begin
    w_do      = r_do;
    w_ch      = r_ch;
    w_vld     = 1'b0;
    w_err     = r_err;
    w_ptr_n   = r_ptr;
    w_dwell_n = r_dwell;
    if (bus.En)
      case (w_mode)
        M_DIRECT: begin
          w_err = !w_sel_ok;
          if (w_sel_ok) begin
            w_do  = w_data[bus.Sel];
            w_ch  = bus.Sel;
            w_vld = bus.Din_vld[bus.Sel];
          end
        end
        M_SCAN: begin
          w_do      = w_data[w_ptr];
          w_ch      = w_ptr;
          w_vld     = bus.Din_vld[w_ptr];
          w_err     = 1'b0;
          w_dwell_n = w_last ? '0 : w_dwell + 8'd1;
          w_ptr_n   = !w_last ? w_ptr : (w_ptr == P_LAST) ? '0 : w_ptr + 1'b1;
        end
        M_PRIO: begin
          w_err = 1'b0;
          w_vld = w_pany;
          if (w_pany) begin
            w_do = w_data[w_pk];
            w_ch = w_pk;
          end
        end
        default: ;
      endcase
  end
  always_ff @(posedge Clk)
    if (!Rst_n) begin
      r_do    <= '0;
      r_vld   <= 1'b0;
      r_ch    <= '0;
      r_err   <= 1'b0;
      r_ptr   <= '0;
      r_dwell <= '0;
      r_prev  <= M_HOLD;
    end else begin
      r_do    <= w_do;
      r_vld   <= w_vld;
      r_ch    <= w_ch;
      r_err   <= w_err;
      r_ptr   <= w_ptr_n;
      r_dwell <= w_dwell_n;
      r_prev  <= w_mode;
    end
  assign bus.Do     = r_do;
  assign bus.Do_vld = r_vld;
  assign bus.Do_ch  = r_ch;
  assign bus.Err    = r_err;
endmodule

// File: tb/tb_mux_scan_nto1.sv
// tb_mux_scan_nto1: three mux instances (CH/DWELL 4/4, 4/1, 5/3) against a scan-count model
module tb_mux_scan_nto1;
  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [2:0]  sel;
  logic [39:0] din;
  logic [4:0]  dvld;
  logic [1:0]  last_mode;
  int n_chk = 0, n_fail = 0;
  bit chk_on = 1'b0;
  always #5 Clk = ~Clk;
  mux_scan_nto1_if #(.CH(4), .W(8)) b0 ();
  mux_scan_nto1_if #(.CH(4), .W(8)) b1 ();
  mux_scan_nto1_if #(.CH(5), .W(8)) b2 ();
  assign b0.En = en;  assign b0.Mode = mode; assign b0.Sel = sel[1:0]; assign b0.Din = din[31:0]; assign b0.Din_vld = dvld[3:0];
  assign b1.En = en;  assign b1.Mode = mode; assign b1.Sel = sel[1:0]; assign b1.Din = din[31:0]; assign b1.Din_vld = dvld[3:0];
  assign b2.En = en;  assign b2.Mode = mode; assign b2.Sel = sel;      assign b2.Din = din;        assign b2.Din_vld = dvld;
  mux_scan_nto1 #(.CH(4), .W(8), .DWELL(4)) u0 (.Clk(Clk), .Rst_n(Rst_n), .bus(b0));
  mux_scan_nto1 #(.CH(4), .W(8), .DWELL(1)) u1 (.Clk(Clk), .Rst_n(Rst_n), .bus(b1));
  mux_scan_nto1 #(.CH(5), .W(8), .DWELL(3)) u2 (.Clk(Clk), .Rst_n(Rst_n), .bus(b2));
  // scan position is derived from the number of enabled SCAN cycles since entry
  typedef struct {
    logic [7:0] d;
    logic       v;
    int         c;
    logic       e;
    int         cnt;
    logic [1:0] prev;
  } st_t;
  st_t m [3];
  int chs [3] = '{4, 4, 5};
  int dws [3] = '{4, 1, 3};
  int sws [3] = '{2, 2, 3};
  function automatic st_t step(st_t s, int ch, int dw, int sw);
    st_t r = s;
    int sl, p;
    if (!Rst_n) begin
      r.d = '0; r.v = 1'b0; r.c = 0; r.e = 1'b0; r.cnt = 0; r.prev = 2'd3;
      return r;
    end
    sl = int'(sel) % (1 << sw);
    r.v = 1'b0;
    if (en)
      case (mode)
        2'd0: if (sl < ch) begin
                r.d = din[sl*8 +: 8]; r.c = sl; r.v = dvld[sl]; r.e = 1'b0;
              end else r.e = 1'b1;
        2'd1: begin
                if (s.prev != 2'd1) r.cnt = 0;
                p = (r.cnt / dw) % ch;
                r.d = din[p*8 +: 8]; r.c = p; r.v = dvld[p]; r.e = 1'b0;
                r.cnt = r.cnt + 1;
              end
        2'd2: begin
                r.e = 1'b0;
                for (int k = ch - 1; k >= 0; k--)
                  if (dvld[k]) begin r.d = din[k*8 +: 8]; r.c = k; r.v = 1'b1; end
              end
        default: ;
      endcase
    r.prev = mode;
    return r;
  endfunction
  always @(posedge Clk)
    for (int i = 0; i < 3; i++) m[i] = step(m[i], chs[i], dws[i], sws[i]);
  task automatic cmp(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic chk_inst(int i, logic [7:0] d, logic v, logic [2:0] c, logic e);
    cmp($sformatf("u%0d.Do", i),     32'(d), 32'(m[i].d));
    cmp($sformatf("u%0d.Do_vld", i), 32'(v), 32'(m[i].v));
    cmp($sformatf("u%0d.Do_ch", i),  32'(c), 32'(m[i].c));
    cmp($sformatf("u%0d.Err", i),    32'(e), 32'(m[i].e));
  endtask
  always @(negedge Clk)
    if (chk_on) begin
      chk_inst(0, b0.Do, b0.Do_vld, {1'b0, b0.Do_ch}, b0.Err);
      chk_inst(1, b1.Do, b1.Do_vld, {1'b0, b1.Do_ch}, b1.Err);
      chk_inst(2, b2.Do, b2.Do_vld, b2.Do_ch, b2.Err);
    end
  task automatic go(logic r, logic e, logic [1:0] md, logic [2:0] s, logic [4:0] v);
    Rst_n = r; en = e; mode = md; sel = s; dvld = v;
    @(posedge Clk);
    #2;
  endtask
  initial begin
    Rst_n = 1'b0; en = 1'b1; mode = 2'd1; sel = '0; dvld = '1;
    din = {8'($urandom), $urandom};
    @(posedge Clk);
    #2;
    chk_on = 1'b1;
    go(1'b0, 1'b1, 2'd1, 3'd0, 5'h1f);
    cmp("rst.Do", 32'(b0.Do), 0);
    cmp("rst.Do_vld", 32'(b0.Do_vld), 0);
    cmp("rst.Do_ch", 32'(b0.Do_ch), 0);
    cmp("rst.Err", 32'(b2.Err), 0);
    for (int k = 0; k < 20; k++) begin
      go(1'b1, 1'b1, 2'd1, 3'd0, 5'h1f);
      cmp("scan_dw4.Do_ch", 32'(b0.Do_ch), (k / 4) % 4);
      if (k < 8) cmp("scan_dw1.Do_ch", 32'(b1.Do_ch), k % 4);
    end
    go(1'b1, 1'b1, 2'd1, 3'd0, 5'h1f);
    go(1'b1, 1'b1, 2'd1, 3'd0, 5'h1f);
    for (int k = 0; k < 3; k++) begin
      go(1'b1, 1'b0, 2'd1, 3'd0, 5'h1f);
      cmp("freeze.Do_vld", 32'(b0.Do_vld), 0);
      cmp("freeze.Do_ch", 32'(b0.Do_ch), 1);
    end
    for (int k = 0; k < 3; k++) begin
      go(1'b1, 1'b1, 2'd1, 3'd0, 5'h1f);
      cmp("resume.Do_ch", 32'(b0.Do_ch), (k < 2) ? 1 : 2);
    end
    go(1'b1, 1'b1, 2'd3, 3'd0, 5'h1f);
    cmp("hold.Do_vld", 32'(b0.Do_vld), 0);
    for (int k = 0; k < 5; k++) begin
      go(1'b1, 1'b1, 2'd1, 3'd0, 5'h1f);
      cmp("reentry.Do_ch", 32'(b0.Do_ch), (k < 4) ? 0 : 1);
    end
    din = 40'hEE_DD_CC_BB_AA;
    for (int k = 0; k < 4; k++) begin
      go(1'b1, 1'b1, 2'd0, 3'(k), 5'h1f);
      cmp("direct.Do", 32'(b0.Do), 32'hAA + 32'h11 * k);
      cmp("direct.Do_ch", 32'(b0.Do_ch), k);
      cmp("direct.Do_vld", 32'(b0.Do_vld), 1);
    end
    go(1'b1, 1'b1, 2'd0, 3'd2, 5'b11011);
    cmp("direct_inv.Do", 32'(b0.Do), 32'hCC);
    cmp("direct_inv.Do_vld", 32'(b0.Do_vld), 0);
    go(1'b1, 1'b1, 2'd2, 3'd0, 5'b01010);
    cmp("prio1010.Do_ch", 32'(b0.Do_ch), 1);
    cmp("prio1010.Do", 32'(b0.Do), 32'hBB);
    go(1'b1, 1'b1, 2'd2, 3'd0, 5'b01000);
    cmp("prio1000.Do_ch", 32'(b0.Do_ch), 3);
    go(1'b1, 1'b1, 2'd2, 3'd0, 5'b00000);
    cmp("prio0.Do_vld", 32'(b0.Do_vld), 0);
    cmp("prio0.Do_ch", 32'(b0.Do_ch), 3);
    cmp("prio0.Do", 32'(b0.Do), 32'hDD);
    go(1'b1, 1'b1, 2'd0, 3'd6, 5'h1f);
    cmp("illegal.Err", 32'(b2.Err), 1);
    cmp("illegal.Do_vld", 32'(b2.Do_vld), 0);
    cmp("illegal.Do", 32'(b2.Do), 32'hDD);
    cmp("illegal.Do_ch", 32'(b2.Do_ch), 3);
    go(1'b1, 1'b1, 2'd0, 3'd4, 5'h1f);
    cmp("legal.Err", 32'(b2.Err), 0);
    cmp("legal.Do", 32'(b2.Do), 32'hEE);
    cmp("legal.Do_ch", 32'(b2.Do_ch), 4);
    last_mode = 2'd0;
    // en is only dropped while the mode is unchanged, so SCAN entry always lands on an enabled cycle
    for (int t = 0; t < 3000; t++) begin
      logic       r, e;
      logic [1:0] md;
      r  = ($urandom_range(63) != 0);
      md = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : last_mode;
      e  = (md != last_mode) ? 1'b1 : ($urandom_range(5) != 0);
      din = {8'($urandom), $urandom};
      go(r, e, md, 3'($urandom_range(7)), 5'($urandom));
      last_mode = r ? md : 2'd3;
    end
    @(negedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
